vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Pixel-colour stage directly downstream of the VGA sync generator (`VGA_HS_VS`).
- Consumes hs, vs, active-area flag and pixel coordinates; produces registered 3-bit-per-channel RGB for the Go Board VGA DAC.
- Re-times hs/vs so they stay aligned with the RGB.
- Provides selectable test patterns, including a frame-animated bouncing box.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- BOX_SIZE, 32, bouncing-box edge length in pixels.
- STEP, 1, box movement per frame in pixels per axis.

Ports:
- i_clk  in  1  pixel clock (25 MHz).
- i_reset_n  in  1  asynchronous reset, active-low.
- i_hs  in  1  horizontal sync from the sync generator, active-low.
- i_vs  in  1  vertical sync from the sync generator, active-low.
- i_activeArea  in  1  high while (i_px, i_py) is visible.
- i_px  in  10  pixel column.
- i_py  in  10  pixel row.
- i_mode  in  2  pattern select; sampled only at the frame tick.
- o_hs  out  1  i_hs delayed by 2 cycles.
- o_vs  out  1  i_vs delayed by 2 cycles.
- o_red  out  3  red.
- o_grn  out  3  green.
- o_blu  out  3  blue.

Behaviour:
- Reset: one clock; async active-low reset.
  - While i_reset_n=0: o_hs=1, o_vs=1 (inactive level); o_red/o_grn/o_blu=0.
  - Internal state while in reset: mode=0, frame counter=0, box x=0, y=0, dx=+, dy=+; pipeline flags cleared.
  - Reset mid-frame: outputs go to reset values immediately. Animation restarts from (0,0) at the first frame tick after release.
- Pipeline: fixed 2-cycle latency.
  - Stage 1 registers hs, vs, active and pattern colour computed from i_px/i_py.
  - Stage 2 registers outputs.
  - RGB is forced to 0 whenever the delayed active flag is 0.
- Frame tick: asserted one cycle when i_vs=0 and the previous-cycle sample of i_vs was 1 (vsync start). No visible pixels occur during vsync, so all frame-state updates are tear-free.
- On the frame tick:
  - r_mode <= i_mode.
  - Frame counter (8 bit) increments and wraps 255->0.
  - Box position updates as below.
- Box update, x axis (y identical with V_ACTIVE):
  - dx=+: if x+STEP > H_ACTIVE-BOX_SIZE then dx<=-, x<=x-STEP; else x<=x+STEP.
  - dx=-: if x < STEP then dx<=+, x<=x+STEP; else x<=x-STEP.
  - Range of x is 0..H_ACTIVE-BOX_SIZE; the box never leaves the screen.
  - Both axes may reflect on the same tick (corner hit).
- Modes (r_mode):
  - 0, colour bars: 8 bars, each H_ACTIVE/8 wide. Index k = bar number from comparator chain (no divider). Colour bits = k[2:0] replicated: red={3{k[2]}}, grn={3{k[1]}}, blu={3{k[0]}}. Bar 0 black, bar 7 white.
  - 1, checkerboard: 32x32 squares; white if px[5]^py[5], else black.
  - 2, bouncing box: white where x<=px<x+BOX_SIZE and y<=py<y+BOX_SIZE; elsewhere blue (0,0,7).
  - 3, gradient: red=px[9:7], grn=py[8:6], blu=frame_counter[7:5].
- Widths: comparisons use 11-bit sums to avoid overflow at x+BOX_SIZE. i_px/i_py are trusted only while i_activeArea=1.
- A mode change mid-frame has no visible effect until the next frame tick.

Optional Feature:
- Macro: VGA_PATTERN_BORDER_EN.
- Defined: a white (7,7,7) 1-pixel border overrides any pattern where px=0, px=H_ACTIVE-1, py=0 or py=V_ACTIVE-1 (active pixels only). Latency is unchanged.
- Undefined: no border logic; pattern output is unmodified.

Decomposition:
- Package vga_pkg:
  - H_ACTIVE/V_ACTIVE defaults.
  - 2-bit mode enum: MODE_BARS, MODE_CHECKER, MODE_BOX, MODE_GRADIENT.
  - Colour constants: BLACK, WHITE, BLUE as 9-bit {r,g,b}.
- Sub-module vga_bounce_box: holds x, y, dx, dy; input frame tick; outputs x, y. It is the only independent state machine.

Test Plan:
- Reset held for 10 cycles mid-frame -> o_hs=o_vs=1, RGB=0 throughout; after release, first frame tick sets box at x=1, y=1.
- Mode 0, active pixel px=85, py=10 -> 2 cycles later RGB=(0,0,7). px=639 -> (7,7,7). i_activeArea=0 -> (0,0,0).
- i_hs toggled 1->0 at cycle N -> o_hs falls at cycle N+2. Same for i_vs.
- Mode 2 over 620 frame ticks with STEP=1, BOX_SIZE=32 -> x reaches 608 at tick 608, tick 609 gives x=607 with dx=-. y reflects at 448 -> 447.
- i_mode changed 0->1 mid-frame -> pixels stay bars until the next vs falling edge, then checkerboard: px=32, py=0 -> white.
- With VGA_PATTERN_BORDER_EN, mode 2 -> pixel (0,200) white, pixel (1,200) blue when the box is elsewhere. Without the macro -> (0,200) blue.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA pattern generator slice.
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned V_ACTIVE_DEF = 480;

    typedef enum logic [1:0] {
        MODE_BARS     = 2'd0,
        MODE_CHECKER  = 2'd1,
        MODE_BOX      = 2'd2,
        MODE_GRADIENT = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_POS = 1'b0,
        DIR_NEG = 1'b1
    } dir_e;

    // Colours packed as {r[2:0], g[2:0], b[2:0]}
    localparam logic [8:0] BLACK = 9'b000_000_000;
    localparam logic [8:0] WHITE = 9'b111_111_111;
    localparam logic [8:0] BLUE  = 9'b000_000_111;

    function automatic logic [8:0] bar_colour(input logic [2:0] k);
        return {{3{k[2]}}, {3{k[1]}}, {3{k[0]}}};
    endfunction

    // One reflecting step along an axis; returns {next_dir, next_pos}.
    function automatic logic [10:0] bounce_step(input logic [9:0] pos, input dir_e dir,
                                                input logic [10:0] lim, input logic [10:0] step);
        logic [10:0] up;
        up = {1'b0, pos} + step;
        if (dir == DIR_POS)
            return (up > lim) ? {DIR_NEG, pos - step[9:0]} : {DIR_POS, up[9:0]};
        return ({1'b0, pos} < step) ? {DIR_POS, up[9:0]} : {DIR_NEG, pos - step[9:0]};
    endfunction

endpackage

// File: rtl/vga_pattern_gen_if.sv
// Video timing in / RGB out bundle between the sync generator, pattern stage and DAC.
interface vga_pattern_gen_if;
    logic       i_hs;
    logic       i_vs;
    logic       i_activeArea;
    logic [9:0] i_px;
    logic [9:0] i_py;
    logic [1:0] i_mode;
    logic       o_hs;
    logic       o_vs;
    logic [2:0] o_red;
    logic [2:0] o_grn;
    logic [2:0] o_blu;

    modport master (
        output i_hs, i_vs, i_activeArea, i_px, i_py, i_mode,
        input  o_hs, o_vs, o_red, o_grn, o_blu
    );

    modport slave (
        input  i_hs, i_vs, i_activeArea, i_px, i_py, i_mode,
        output o_hs, o_vs, o_red, o_grn, o_blu
    );
endinterface

// File: rtl/vga_bounce_box.sv
// Bouncing-box position state: moves STEP pixels per axis on each frame tick, reflecting at edges.
module vga_bounce_box
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    output logic [9:0] x,
    output logic [9:0] y
);

    localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
    localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);
    localparam logic [10:0] STEP11 = 11'(STEP);

    dir_e        dx;
    dir_e        dy;
    logic [10:0] nx;
    logic [10:0] ny;

    always_comb begin
        nx = bounce_step(x, dx, X_MAX, STEP11);
        ny = bounce_step(y, dy, Y_MAX, STEP11);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x  <= '0;
            y  <= '0;
            dx <= DIR_POS;
            dy <= DIR_POS;
        end else if (tick) begin
            x  <= nx[9:0];
            y  <= ny[9:0];
            dx <= dir_e'(nx[10]);
            dy <= dir_e'(ny[10]);
        end
    end

endmodule

// File: rtl/vga_pattern_gen.sv
// Two-stage pixel colour pipeline with selectable test patterns and re-timed syncs.
// Optional macro VGA_PATTERN_BORDER_EN adds a white 1-pixel frame border.
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned BOX_SIZE = 32,
    parameter int unsigned STEP     = 1
) (
    input  logic               i_clk,
    input  logic               i_reset_n,
    vga_pattern_gen_if.slave   vif
);

    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic       vs_prev;
    logic       frame_tick;
    mode_e      r_mode;
    logic [7:0] frame_cnt;
    logic [9:0] box_x;
    logic [9:0] box_y;
    logic [2:0] bar_k;
    logic       in_box;
    logic [8:0] colour;
    logic       hs1;
    logic       vs1;
    logic       act1;
    logic [8:0] col1;

    assign frame_tick = vs_prev & ~vif.i_vs;

    vga_bounce_box #(
        .H_ACTIVE(H_ACTIVE),
        .V_ACTIVE(V_ACTIVE),
        .BOX_SIZE(BOX_SIZE),
        .STEP    (STEP)
    ) u_box (
        .clk  (i_clk),
        .rst_n(i_reset_n),
        .tick (frame_tick),
        .x    (box_x),
        .y    (box_y)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            vs_prev   <= 1'b1;
            r_mode    <= MODE_BARS;
            frame_cnt <= '0;
        end else begin
            vs_prev <= vif.i_vs;
            if (frame_tick) begin
                r_mode    <= mode_e'(vif.i_mode);
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

    // Bar index from a comparator chain; the last threshold passed wins.
    always_comb begin
        bar_k = '0;
        for (int unsigned b = 1; b < 8; b++)
            if ({1'b0, vif.i_px} >= 11'(b * BAR_W))
                bar_k = 3'(b);
    end

    always_comb begin
        in_box = ({1'b0, vif.i_px} >= {1'b0, box_x}) &&
                 ({1'b0, vif.i_px} <  {1'b0, box_x} + 11'(BOX_SIZE)) &&
                 ({1'b0, vif.i_py} >= {1'b0, box_y}) &&
                 ({1'b0, vif.i_py} <  {1'b0, box_y} + 11'(BOX_SIZE));
        colour = BLACK;
        case (r_mode)
            MODE_BARS:     colour = bar_colour(bar_k);
            MODE_CHECKER:  colour = (vif.i_px[5] ^ vif.i_py[5]) ? WHITE : BLACK;
            MODE_BOX:      colour = in_box ? WHITE : BLUE;
            MODE_GRADIENT: colour = {vif.i_px[9:7], vif.i_py[8:6], frame_cnt[7:5]};
            default:       colour = BLACK;
        endcase
`ifdef VGA_PATTERN_BORDER_EN
        if (vif.i_px == '0 || vif.i_px == 10'(H_ACTIVE - 1) ||
            vif.i_py == '0 || vif.i_py == 10'(V_ACTIVE - 1))
            colour = WHITE;
`endif
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            hs1       <= 1'b1;
            vs1       <= 1'b1;
            act1      <= 1'b0;
            col1      <= BLACK;
            vif.o_hs  <= 1'b1;
            vif.o_vs  <= 1'b1;
            vif.o_red <= '0;
            vif.o_grn <= '0;
            vif.o_blu <= '0;
        end else begin
            hs1  <= vif.i_hs;
            vs1  <= vif.i_vs;
            act1 <= vif.i_activeArea;
            col1 <= colour;
            vif.o_hs <= hs1;
            vif.o_vs <= vs1;
            {vif.o_red, vif.o_grn, vif.o_blu} <= act1 ? col1 : BLACK;
        end
    end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Scoreboard bench for vga_pattern_gen: directed pixels/syncs, expected values queued with due cycle.
module tb_vga_pattern_gen;

    typedef struct {
        int         due;
        logic       hs;
        logic       vs;
        logic [8:0] rgb;
        string      name;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    int         ticks = 0;
    logic [1:0] m_in = 2'd0;
    exp_t       q[$];
    exp_t       e;

    vga_pattern_gen_if vif();

    vga_pattern_gen #(
        .H_ACTIVE(640),
        .V_ACTIVE(480),
        .BOX_SIZE(32),
        .STEP    (1)
    ) dut (
        .i_clk    (clk),
        .i_reset_n(rst_n),
        .vif      (vif)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares every queued expectation on the cycle it falls due.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            n_cmp++;
            if ({vif.o_hs, vif.o_vs, vif.o_red, vif.o_grn, vif.o_blu} !== {e.hs, e.vs, e.rgb}
                || e.due != cyc) begin
                n_bad++;
                $display("FAIL %s: got hs=%b vs=%b rgb=%o, expected hs=%b vs=%b rgb=%o",
                         e.name, vif.o_hs, vif.o_vs, {vif.o_red, vif.o_grn, vif.o_blu},
                         e.hs, e.vs, e.rgb);
            end
        end
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] bx(input int px, input int py, input logic [8:0] c);
`ifdef VGA_PATTERN_BORDER_EN
        if (px == 0 || px == 639 || py == 0 || py == 479) return 9'o777;
`endif
        return c;
    endfunction

    task automatic push(input int due, input logic hs, input logic vs,
                        input logic [8:0] rgb, input string name);
        exp_t x;
        x.due = due; x.hs = hs; x.vs = vs; x.rgb = rgb; x.name = name;
        q.push_back(x);
    endtask

    task automatic drive(input logic hs, input logic vs, input logic act, input int px,
                         input int py, input logic chk, input logic [8:0] rgb, input string name);
        @(negedge clk);
        vif.i_hs = hs;
        vif.i_vs = vs;
        vif.i_activeArea = act;
        vif.i_px = 10'(px);
        vif.i_py = 10'(py);
        vif.i_mode = m_in;
        if (chk) push(cyc + 2, hs, vs, rgb, name);
    endtask

    task automatic pix(input int px, input int py, input logic [8:0] rgb, input string name);
        drive(1'b1, 1'b1, 1'b1, px, py, 1'b1, bx(px, py, rgb), name);
    endtask

    task automatic tick(input logic [1:0] m);
        m_in = m;
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 9'o0, "");
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 9'o0, "");
        ticks++;
    endtask

    task automatic tick_to(input int n, input logic [1:0] m);
        while (ticks < n) tick(m);
    endtask

    // Reset asserted mid-line with an active pixel and hs low on the inputs.
    task automatic hold_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst_n = 1'b0;
            vif.i_hs = 1'b0;
            vif.i_vs = 1'b1;
            vif.i_activeArea = 1'b1;
            vif.i_px = 10'd639;
            vif.i_py = 10'd100;
            if (i < n - 1) push(cyc + 1, 1'b1, 1'b1, 9'o0, "reset_out");
        end
        @(negedge clk);
        rst_n = 1'b1;
        vif.i_hs = 1'b1;
        vif.i_activeArea = 1'b0;
        ticks = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 9'o0, "");
    endtask

    initial begin
        vif.i_hs = 1'b1; vif.i_vs = 1'b1; vif.i_activeArea = 1'b0;
        vif.i_px = '0; vif.i_py = '0; vif.i_mode = '0;
        hold_reset(4);
        idle(2);

        // Colour bars (mode 0 from reset), bar width 80
        pix(85, 10, 9'o007, "bar1_px85");
        pix(639, 10, 9'o777, "bar7_px639");
        drive(1'b1, 1'b1, 1'b0, 85, 10, 1'b1, 9'o000, "inactive_black");
        pix(79, 10, 9'o000, "bar0_px79");
        pix(80, 10, 9'o007, "bar1_px80");
        pix(160, 10, 9'o070, "bar2_px160");
        pix(400, 10, 9'o707, "bar5_px400");
        pix(0, 10, 9'o000, "bar0_px0");

        // Sync re-timing: every cycle checked so a latency error shows up
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 9'o0, "hs_pre");
        drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 9'o0, "hs_fall");
        drive(1'b0, 1'b1, 1'b0, 0, 0, 1'b1, 9'o0, "hs_low");
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 9'o0, "hs_rise");
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 9'o0, "vs_fall");
        drive(1'b1, 1'b0, 1'b0, 0, 0, 1'b1, 9'o0, "vs_low");
        drive(1'b1, 1'b1, 1'b0, 0, 0, 1'b1, 9'o0, "vs_rise");
        tick(2'd2);
        pix(400, 10, 9'o007, "mode2_pre_reset");
        idle(2);

        // Mid-frame reset, then mode must be back to bars
        hold_reset(10);
        m_in = 2'd0;
        pix(400, 10, 9'o707, "bars_after_reset");
        idle(2);

        // Bouncing box: tick 1 -> (1,1)
        tick(2'd2);
        pix(0, 0, 9'o007, "box_t1_00");
        pix(1, 1, 9'o777, "box_t1_11");
        pix(32, 32, 9'o777, "box_t1_32");
        pix(33, 32, 9'o007, "box_t1_33x");
        pix(32, 33, 9'o007, "box_t1_33y");
        tick_to(448, 2'd2);
        pix(448, 448, 9'o777, "box_t448_in");
        pix(447, 448, 9'o007, "box_t448_left");
        pix(479, 479, 9'o777, "box_t448_far");
        pix(480, 479, 9'o007, "box_t448_out");
        tick_to(449, 2'd2);
        pix(448, 470, 9'o007, "box_t449_left");
        pix(449, 447, 9'o777, "box_t449_yrefl");
        pix(480, 478, 9'o777, "box_t449_far");
        pix(480, 479, 9'o007, "box_t449_below");
        tick_to(608, 2'd2);
        pix(608, 288, 9'o777, "box_t608_in");
        pix(639, 319, 9'o777, "box_t608_edge");
        pix(607, 288, 9'o007, "box_t608_left");
        tick_to(609, 2'd2);
        pix(607, 287, 9'o777, "box_t609_xrefl");
        pix(638, 318, 9'o777, "box_t609_far");
        pix(639, 318, 9'o007, "box_t609_right");
        tick_to(620, 2'd2);
        pix(596, 276, 9'o777, "box_t620_in");
        pix(595, 276, 9'o007, "box_t620_left");
        pix(0, 200, 9'o007, "border_0_200");
        pix(1, 200, 9'o007, "border_1_200");

        // Mode change mid-frame only takes effect at the next frame tick
        tick(2'd0);
        m_in = 2'd1;
        pix(100, 10, 9'o007, "midframe_still_bars");
        pix(32, 0, 9'o000, "midframe_bars_32_0");
        tick(2'd1);
        pix(100, 10, 9'o777, "checker_100_10");
        pix(32, 0, 9'o777, "checker_32_0");
        pix(32, 40, 9'o000, "checker_32_40");

        // Gradient: frame counter 623 mod 256 = 111 -> blu 3
        tick(2'd3);
        pix(200, 300, 9'o143, "grad_f111_a");
        pix(600, 100, 9'o413, "grad_f111_b");
        tick_to(656, 2'd3);
        pix(200, 300, 9'o144, "grad_f144");
        tick_to(768, 2'd3);
        pix(200, 300, 9'o140, "grad_wrap0");

        idle(4);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
